// File: rtl/d_bus_arbiter.sv
// Round-robin arbiter sharing the single RAM data port between two dcaches.
// A grant is held for one full block of WORDS_PER_BLK words, then priority rotates.
module d_bus_arbiter #(
  parameter int unsigned WORDS_PER_BLK = 2,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][ADDR_W-1:0] daddr,
  input  logic [1:0][DATA_W-1:0] dstore,
  output logic [1:0]             dwait_out,
  output logic [DATA_W-1:0]      dload_out,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  input  logic [DATA_W-1:0]      ramload,
  input  logic                   ramwait,
  output logic [1:0]             grant
);

  localparam int unsigned WCNT_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              r_state, w_nxt_state;
  logic                r_owner, w_nxt_owner;
  logic                r_last,  w_nxt_last;
  logic [WCNT_W-1:0]   r_wcnt,  w_nxt_wcnt;
  logic [1:0]          w_req;

  assign w_req     = dREN | dWEN;
  assign dload_out = ramload;

  // State registers; last=1 after reset so core 0 wins the first tie
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_wcnt  <= w_nxt_wcnt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_wcnt  = r_wcnt;
    dwait_out   = 2'b11;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    grant       = 2'b00;

    unique case (r_state)
      IDLE: begin
        if (w_req != 2'b00) begin
          w_nxt_state = BUSY;
          w_nxt_wcnt  = '0;
          unique case (w_req)
            2'b01:   w_nxt_owner = 1'b0;
            2'b10:   w_nxt_owner = 1'b1;
            default: w_nxt_owner = !r_last;
          endcase
        end
      end
      BUSY: begin
        ramaddr           = daddr[r_owner];
        ramstore          = dstore[r_owner];
        grant[r_owner]    = 1'b1;
        ramWEN            = dWEN[r_owner];
        ramREN            = dREN[r_owner] & !dWEN[r_owner];
        dwait_out[r_owner] = ramwait;
        if (!w_req[r_owner]) begin
          // Owner released early: block counts as finished
          w_nxt_state = IDLE;
          w_nxt_wcnt  = '0;
          w_nxt_last  = r_owner;
        end else if (!ramwait) begin
          if (r_wcnt == WCNT_W'(WORDS_PER_BLK - 1)) begin
            w_nxt_state = IDLE;
            w_nxt_wcnt  = '0;
            w_nxt_last  = r_owner;
          end else begin
            w_nxt_wcnt  = WCNT_W'(r_wcnt + 1'b1);
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_bus_arbiter.sv
// Self-checking bench for d_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of block ownership.
module tb_d_bus_arbiter;

  localparam int WPB = 2;

  logic             CLK;
  logic             RST;
  logic [1:0]       dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait_out;
  logic [31:0]      dload_out;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ramwait;
  logic [1:0]       grant;

  int errors = 0;
  int checks = 0;

  // Model: is a block in flight, who owns it, words done so far, last finisher
  bit   m_busy;
  logic m_owner;
  int   m_done;
  logic m_last;

  logic [1:0] obs_grant, obs_dwait;
  logic       obs_ren, obs_wen;

  d_bus_arbiter #(.WORDS_PER_BLK(WPB), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait_out(dwait_out), .dload_out(dload_out),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait), .grant(grant)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_done = 0; m_last = 1'b1;
  endtask

  // Compare all outputs at the falling edge, then advance model at the rising edge
  task automatic tick();
    logic [1:0]  e_grant, e_dwait, req;
    logic [31:0] e_addr, e_store;
    logic        e_ren, e_wen;
    @(negedge CLK);
    req = dREN | dWEN;
    e_grant = 2'b00; e_dwait = 2'b11; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = 32'h0; e_store = 32'h0;
    if (m_busy) begin
      e_grant = m_owner ? 2'b10 : 2'b01;
      e_addr  = daddr[m_owner];
      e_store = dstore[m_owner];
      e_wen   = dWEN[m_owner];
      e_ren   = dREN[m_owner] && !dWEN[m_owner];
      e_dwait = m_owner ? {ramwait, 1'b1} : {1'b1, ramwait};
    end
    obs_grant = grant; obs_dwait = dwait_out; obs_ren = ramREN; obs_wen = ramWEN;
    chk("grant",    32'(grant),     32'(e_grant));
    chk("dwait",    32'(dwait_out), 32'(e_dwait));
    chk("ramREN",   32'(ramREN),    32'(e_ren));
    chk("ramWEN",   32'(ramWEN),    32'(e_wen));
    chk("ramaddr",  ramaddr,        e_addr);
    chk("ramstore", ramstore,       e_store);
    chk("dload",    dload_out,      ramload);
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else if (!m_busy) begin
      if (req == 2'b11) begin m_busy = 1'b1; m_owner = !m_last; m_done = 0; end
      else if (req != 2'b00) begin m_busy = 1'b1; m_owner = req[1]; m_done = 0; end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0; m_done = 0; m_last = m_owner;
    end else if (!ramwait) begin
      m_done++;
      if (m_done == WPB) begin m_busy = 1'b0; m_done = 0; m_last = m_owner; end
    end
    #1;
    ramload = $urandom;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  task automatic rand_data();
    daddr[0] = $urandom; daddr[1] = $urandom;
    dstore[0] = $urandom; dstore[1] = $urandom;
  endtask

  logic [1:0] pat [9];

  initial begin
    model_reset();
    RST = 1'b1; dREN = 2'b11; dWEN = 2'b00; ramwait = 1'b0;
    daddr = '0; dstore = '0; ramload = 32'h0;

    // Reset held two cycles with both cores requesting
    tick(); tick();
    chk("rst_grant", 32'(obs_grant), 32'h0);
    chk("rst_dwait", 32'(obs_dwait), 32'h3);
    chk("rst_ren",   32'(obs_ren),   32'h0);

    // Single core 1 read of two words
    RST = 1'b0; dREN = 2'b10; daddr[1] = 32'h40; dstore[1] = 32'h1234;
    tick();
    chk("single_arb", 32'(obs_grant), 32'h0);
    tick();
    chk("single_w0_grant", 32'(obs_grant), 32'h2);
    chk("single_w0_dwait", 32'(obs_dwait), 32'h1);
    chk("single_w0_ren",   32'(obs_ren),   32'h1);
    daddr[1] = 32'h44;
    tick();
    chk("single_w1_grant", 32'(obs_grant), 32'h2);
    chk("single_w1_dwait", 32'(obs_dwait), 32'h1);
    dREN = 2'b00;
    tick();
    chk("single_done", 32'(obs_grant), 32'h0);

    // Contention: both write from reset, ownership alternates 0,1,0
    do_reset();
    dREN = 2'b00; dWEN = 2'b11; ramwait = 1'b0;
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b01; pat[3] = 2'b00; pat[4] = 2'b10;
    pat[5] = 2'b10; pat[6] = 2'b00; pat[7] = 2'b01; pat[8] = 2'b01;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      tick();
      chk($sformatf("contend_%0d", i), 32'(obs_grant), 32'(pat[i]));
      if (pat[i] != 2'b00) chk($sformatf("contend_wen_%0d", i), 32'(obs_wen), 32'h1);
    end

    // RAM stall holds the block for five cycles
    do_reset();
    dWEN = 2'b00; dREN = 2'b01; daddr[0] = 32'h100; ramwait = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_grant", 32'(obs_grant), 32'h1);
      chk("stall_dwait", 32'(obs_dwait), 32'h3);
    end
    ramwait = 1'b0;
    tick();
    chk("stall_w0_dwait", 32'(obs_dwait), 32'h2);
    tick();
    chk("stall_w1_grant", 32'(obs_grant), 32'h1);
    dREN = 2'b00;
    tick();
    chk("stall_done", 32'(obs_grant), 32'h0);

    // Early drop by core 0 after word 0 while core 1 waits
    do_reset();
    dREN = 2'b11; rand_data();
    tick();
    tick();
    chk("drop_w0", 32'(obs_grant), 32'h1);
    dREN = 2'b10;
    tick();
    chk("drop_cycle", 32'(obs_grant), 32'h1);
    tick();
    chk("drop_idle", 32'(obs_grant), 32'h0);
    dREN = 2'b11;
    tick();
    chk("drop_c1_w0", 32'(obs_grant), 32'h2);
    tick();
    chk("drop_c1_w1", 32'(obs_grant), 32'h2);
    tick();
    chk("drop_arb", 32'(obs_grant), 32'h0);
    tick();
    chk("drop_c0_again", 32'(obs_grant), 32'h1);

    // Reset during word 1 abandons the block and restores core 0 priority
    do_reset();
    dREN = 2'b11;
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("mrst_w1", 32'(obs_grant), 32'h1);
    RST = 1'b0;
    tick();
    chk("mrst_grant", 32'(obs_grant), 32'h0);
    chk("mrst_dwait", 32'(obs_dwait), 32'h3);
    chk("mrst_ren",   32'(obs_ren),   32'h0);
    tick();
    chk("mrst_core0", 32'(obs_grant), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      RST     = ($urandom_range(0, 59) == 0);
      dREN    = 2'($urandom_range(0, 3));
      dWEN    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      ramwait = ($urandom_range(0, 3) == 0);
      rand_data();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
